// File: rtl/adder_pkg.sv
// Shared constants for the segmented pipelined adder.
// Defaults give a 16-bit adder split into four 4-bit stages.
package adder_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_SEG_WIDTH = 4;

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full adder cell.
// Building block of the ripple segment adder.
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_nbit.sv
// Ripple adder of BITS full-adder cells.
// Also exposes the carry into the top bit for overflow detection.
module adder_nbit #(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout,
    output logic            cmsb
);

    logic [BITS:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < BITS; i++) begin : g_bit
        adder_1bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[BITS];
    assign cmsb = c[BITS-1];

endmodule

// File: rtl/pipelined_adder.sv
// Segmented add/subtract pipeline, one SEG_WIDTH slice per stage.
// Whole pipeline stalls when the output is valid but not taken.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SEG      = (SEG_WIDTH < 1) ? 1 : SEG_WIDTH;
    localparam int NUM_SEGS = (WIDTH < SEG) ? 1 : WIDTH / SEG;

    if (SEG_WIDTH < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of SEG_WIDTH");
    end

    logic [WIDTH-1:0]    b_eff;
    logic                cin_eff;

    logic [WIDTH-1:0]    a_q [NUM_SEGS];
    logic [WIDTH-1:0]    b_q [NUM_SEGS];
    logic [WIDTH-1:0]    s_q [NUM_SEGS];
    logic [NUM_SEGS-1:0] v_q;
    logic [NUM_SEGS-1:0] c_q;
    logic                ovf_q;

    logic [SEG-1:0]      seg_a  [NUM_SEGS];
    logic [SEG-1:0]      seg_b  [NUM_SEGS];
    logic [SEG-1:0]      seg_s  [NUM_SEGS];
    logic                seg_ci [NUM_SEGS];
    logic                seg_co [NUM_SEGS];
    logic                seg_cm [NUM_SEGS];

    // Subtraction is A + ~B + 1; carry_in only matters when adding.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | carry_in;

    assign in_ready  = ~(v_q[NUM_SEGS-1] & ~out_ready);
    assign out_valid = v_q[NUM_SEGS-1];
    assign sum       = s_q[NUM_SEGS-1];
    assign carry_out = c_q[NUM_SEGS-1];
    assign overflow  = ovf_q;

    for (genvar k = 0; k < NUM_SEGS; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign seg_a[k]  = a[SEG-1:0];
            assign seg_b[k]  = b_eff[SEG-1:0];
            assign seg_ci[k] = cin_eff;
        end else begin : g_rest
            assign seg_a[k]  = a_q[k-1][k*SEG +: SEG];
            assign seg_b[k]  = b_q[k-1][k*SEG +: SEG];
            assign seg_ci[k] = c_q[k-1];
        end

        adder_nbit #(
            .BITS (SEG)
        ) u_add (
            .a    (seg_a[k]),
            .b    (seg_b[k]),
            .cin  (seg_ci[k]),
            .sum  (seg_s[k]),
            .cout (seg_co[k]),
            .cmsb (seg_cm[k])
        );
    end

    // Stage registers: each shifts one slot when the output side can move.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NUM_SEGS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (in_ready) begin
            v_q[0] <= in_valid;
            c_q[0] <= seg_co[0];
            a_q[0] <= a;
            b_q[0] <= b_eff;
            s_q[0] <= WIDTH'(seg_s[0]);
            for (int k = 1; k < NUM_SEGS; k++) begin
                v_q[k] <= v_q[k-1];
                c_q[k] <= seg_co[k];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_q[k-1] | (WIDTH'(seg_s[k]) << (k * SEG));
            end
            ovf_q <= seg_cm[NUM_SEGS-1] ^ seg_co[NUM_SEGS-1];
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised and directed bench for pipelined_adder (16-bit, 4 stages).
// Results are predicted from plain integer arithmetic and a FIFO.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] exp_q[$];

    pipelined_adder #(
        .WIDTH     (16),
        .SEG_WIDTH (4)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, carry_out, sum} from integer arithmetic.
    function automatic logic [17:0] ref_op(input logic [15:0] x,
                                           input logic [15:0] y,
                                           input logic ci,
                                           input logic sb);
        int          s;
        logic [16:0] u;
        logic [15:0] r;
        logic        c;
        if (sb) begin
            s = int'($signed(x)) - int'($signed(y));
            r = x - y;
            c = (x >= y);
        end else begin
            s = int'($signed(x)) + int'($signed(y)) + int'(ci);
            u = {1'b0, x} + {1'b0, y} + {16'b0, ci};
            r = u[15:0];
            c = u[16];
        end
        return {(s > 32767 || s < -32768), c, r};
    endfunction

    // Scoreboard: record accepted operations, compare delivered results.
    always @(negedge clk) begin
        if (!n_rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("spurious_out", 32'(out_valid), 32'(0));
                else
                    check("result", 32'({overflow, carry_out, sum}),
                          32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_op(a, b, carry_in, sub));
        end
    end

    // Single operation into an empty pipe; result due 4 edges later.
    task automatic do_op(input string tag, input logic [15:0] x,
                         input logic [15:0] y, input logic ci,
                         input logic sb, input logic [17:0] exp);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        carry_in  = ci;
        sub       = sb;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_early"}, 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_sum"}, 32'(sum), 32'(exp[15:0]));
        check({tag, "_cout"}, 32'(carry_out), 32'(exp[16]));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp[17]));
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Six back-to-back ops; consumer stalls 3 cycles on the first result.
    task automatic run_b2b();
        logic [15:0] oa [6];
        logic [15:0] ob [6];
        logic [15:0] held = '0;
        int          sent = 0;
        int          stalls = 0;
        int          seen = 0;
        int          cyc = 0;
        logic        acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            oa[i] = 16'($urandom);
            ob[i] = 16'($urandom);
        end
        while (seen < 6 && cyc < 60) begin
            if (acc) sent++;
            in_valid = (sent < 6);
            if (sent < 6) begin
                a        = oa[sent];
                b        = ob[sent];
                carry_in = sent[0];
                sub      = sent[1];
            end
            if (out_valid && stalls < 3 && seen == 0) begin
                out_ready = 1'b0;
                if (stalls == 0)
                    held = sum;
                else
                    check("stall_sum", 32'(sum), 32'(held));
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (!out_ready)
                check("stall_in_ready", 32'(in_ready), 32'(0));
            if (stalls == 3 && out_ready) begin
                if (seen == 0)
                    check("stall_release_sum", 32'(sum), 32'(held));
                check("b2b_valid", 32'(out_valid), 32'(1));
                if (out_valid) seen++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (seen < 6)
            check("b2b_timeout", 32'(seen), 32'(6));
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_rst     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle(1);

        do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        do_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        do_op("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        idle(2);

        run_b2b();
        idle(8);
        check("b2b_drain", 32'(exp_q.size()), 32'(0));

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            carry_in  = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        idle(10);
        check("rand_drain", 32'(exp_q.size()), 32'(0));

        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("fill_valid", 32'(out_valid), 32'(1));
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_sum", 32'(sum), 32'(0));
        check("midrst_cout", 32'(carry_out), 32'(0));
        check("midrst_ovf", 32'(overflow), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        n_rst     = 1'b1;
        out_ready = 1'b1;
        idle(2);

        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("flush_quiet", 32'(out_valid), 32'(0));
            @(posedge clk);
            #1;
        end
        do_op("post_rst", 16'h1234, 16'hABCD, 1'b1, 1'b0,
              ref_op(16'h1234, 16'hABCD, 1'b1, 1'b0));
        idle(4);
        check("final_drain", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, total operand/sum width in bits.
REQ-002 SHALL have parameter SEG_WIDTH, default 4, bits added per pipeline stage.
REQ-003 SHALL have derived constant NUM_SEGS = WIDTH/SEG_WIDTH, which is also the pipeline depth.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk, input, 1, rising-edge clock.
REQ-005 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, operand set presented.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have port a, input, WIDTH, operand A.
REQ-009 SHALL have port b, input, WIDTH, operand B.
REQ-010 SHALL have port carry_in, input, 1, carry into bit 0 (add mode only).
REQ-011 SHALL have port sub, input, 1, 0 = A+B+carry_in, 1 = A-B.
REQ-012 SHALL have port out_valid, output, 1, result present.
REQ-013 SHALL have port out_ready, input, 1, consumer takes result.
REQ-014 SHALL have port sum, output, WIDTH, result.
REQ-015 SHALL have port carry_out, output, 1, carry out of MSB (sub: 1 = no borrow).
REQ-016 SHALL have port overflow, output, 1, two's-complement signed overflow.

Function
REQ-017 SHALL accept an operand set on a rising clk edge when in_valid=1 and in_ready=1.
REQ-018 SHALL compute A + ~B + 1 when sub=1, ignoring carry_in; SHALL compute A + B + carry_in when sub=0.
REQ-019 SHALL, in stage k (0..NUM_SEGS-1), add segment k [k*SEG_WIDTH +: SEG_WIDTH] using the carry registered by stage k-1; stage 0 SHALL use the effective carry-in.
REQ-020 SHALL carry the not-yet-added upper operand segments and the already-computed lower sum segments forward through the stage registers alongside a per-stage valid bit.
REQ-021 SHALL assert out_valid with the result exactly NUM_SEGS cycles after acceptance, absent stalls.
REQ-022 SHALL sustain a throughput of one operation per cycle and SHALL deliver results in acceptance order.
REQ-023 SHALL set overflow = (carry into MSB) XOR carry_out.
REQ-024 SHALL drive in_ready = NOT(out_valid AND NOT out_ready), combinationally.
REQ-025 SHALL hold every stage register, including sum, carry_out, overflow and out_valid, while in_ready=0; no operation is lost or duplicated.
REQ-026 SHALL advance bubbles (valid=0 stages) normally; they never produce out_valid.
REQ-027 SHALL, when NUM_SEGS=1, use latency 1 with identical handshake rules.
REQ-028 SHALL cause an elaboration-time error if WIDTH is not a multiple of SEG_WIDTH, or if SEG_WIDTH < 1.
REQ-029 SHALL accept a new operand in the same cycle that out_ready=1 consumes the final-stage result.

Reset
REQ-030 SHALL, while n_rst=0, immediately clear all stage valid bits and data registers: out_valid=0, sum=0, carry_out=0, overflow=0.
REQ-031 SHALL drive in_ready=1 during reset, since out_valid=0.
REQ-032 SHALL discard in-flight operations on reset; no result for them SHALL appear after reset is released.

Structure
REQ-033 SHALL place default WIDTH and SEG_WIDTH constants in shared package adder_pkg.
REQ-034 SHALL implement the per-stage combinational segment adder as sub-module adder_nbit (parameter BITS), built from the existing adder_1bit; the stage carry chain SHALL be instantiated via generate.

Verification (WIDTH=16, SEG_WIDTH=4, latency 4)
REQ-035 SHALL verify: reset asserted mid-run -> out_valid=0, sum=0x0000, in_ready=1 immediately.
REQ-036 SHALL verify: a=0xFFFF, b=0x0001, carry_in=0, sub=0 -> 4 cycles later sum=0x0000, carry_out=1, overflow=0.
REQ-037 SHALL verify: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, carry_out=0, overflow=1.
REQ-038 SHALL verify: a=0x0005, b=0x0007, sub=1, carry_in=1 -> sum=0xFFFE, carry_out=0, overflow=0.
REQ-039 SHALL verify: 6 back-to-back operations with out_ready=0 for 3 cycles at the first result -> in_ready=0 for those 3 cycles, outputs stable, all 6 results then appear in order on consecutive cycles.
REQ-040 SHALL verify: n_rst pulsed low with 2 operations in flight -> no out_valid for them; a new operation afterwards returns its result 4 cycles after acceptance.
